branch_redirect_ctrl: RTL and testbench

Sequences the PC redirect after the branch unit resolves a branch in EX of the 5-stage RV32I pipeline. It registers the resolved target and drives a valid/ready redirect handshake to the fetch unit. It kills younger instructions for a fixed window and keeps saturating branch statistics for the perf CSRs.

---
 rtl/branch_redirect_ctrl.sv | 145 ++++++++++++++
 tb/tb_branch_redirect_ctrl.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_redirect_ctrl.sv
// Branch redirect sequencer: registers a taken EX target, hands it to fetch,
// holds flush for a fixed window and keeps saturating branch statistics.
module branch_redirect_ctrl #(
   parameter int unsigned FLUSH_CYCLES = 2,
   parameter int unsigned CNT_W        = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             ex_valid,
   input  logic [4:0]       ex_BrOp,
   input  logic             ex_NextPCSrc,
   input  logic [31:0]      ex_target,
   input  logic             fetch_ready,
   output logic             redirect_valid,
   output logic [31:0]      redirect_pc,
   output logic             flush,
   output logic             busy,
   output logic             trap_misaligned,
   output logic [CNT_W-1:0] cnt_cond,
   output logic [CNT_W-1:0] cnt_cond_taken,
   output logic [CNT_W-1:0] cnt_jump
);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      REDIRECT = 2'd1,
      FLUSH    = 2'd2
   } state_t;

   localparam logic [3:0]       FLUSH_LD = 4'(FLUSH_CYCLES);
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;

   state_t           state_q, state_d;
   logic [3:0]       fcnt_q, fcnt_d;
   logic [31:0]      pc_q, pc_d;
   logic             trap_q, trap_d;
   logic [CNT_W-1:0] cc_q, cc_d;
   logic [CNT_W-1:0] ct_q, ct_d;
   logic [CNT_W-1:0] cj_q, cj_d;

   logic is_jump;
   logic is_cond;
   logic taken;
   logic aligned;
   logic sample;
   logic hs;
   logic unused_brop;

   assign is_jump     = ex_BrOp[4];
   assign is_cond     = (ex_BrOp[4:3] == 2'b01);
   assign taken       = is_jump | (is_cond & ex_NextPCSrc);
   assign aligned     = (ex_target[1:0] == 2'b00);
   assign sample      = (state_q == IDLE) && ex_valid;
   assign hs          = (state_q == REDIRECT) && fetch_ready;
   assign unused_brop = ^ex_BrOp[2:0];

   function automatic logic [CNT_W-1:0] sat_inc(
      input logic [CNT_W-1:0] v,
      input logic             en
   );
      return (en && (v != CNT_MAX)) ? v + CNT_W'(1) : v;
   endfunction

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (sample && taken && aligned) begin
               state_d = REDIRECT;
            end
         end
         REDIRECT: begin
            if (hs) begin
               state_d = FLUSH;
            end
         end
         FLUSH: begin
            if (fcnt_q <= 4'd1) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         fcnt_q <= '0;
         pc_q   <= '0;
         trap_q <= 1'b0;
         cc_q   <= '0;
         ct_q   <= '0;
         cj_q   <= '0;
      end else begin
         fcnt_q <= fcnt_d;
         pc_q   <= pc_d;
         trap_q <= trap_d;
         cc_q   <= cc_d;
         ct_q   <= ct_d;
         cj_q   <= cj_d;
      end
   end

   // Statistics count every instruction sampled in IDLE, trap or not.
   always_comb begin
      fcnt_d = fcnt_q;
      pc_d   = pc_q;
      trap_d = 1'b0;
      cc_d   = sat_inc(cc_q, sample && is_cond);
      ct_d   = sat_inc(ct_q, sample && is_cond && ex_NextPCSrc);
      cj_d   = sat_inc(cj_q, sample && is_jump);
      if (sample && taken) begin
         if (aligned) begin
            pc_d = ex_target;
         end else begin
            trap_d = 1'b1;
         end
      end
      if (hs) begin
         fcnt_d = FLUSH_LD;
      end else if (state_q == FLUSH) begin
         fcnt_d = fcnt_q - 4'd1;
      end
   end

   always_comb begin
      redirect_valid  = (state_q == REDIRECT);
      flush           = (state_q != IDLE);
      busy            = (state_q != IDLE);
      redirect_pc     = pc_q;
      trap_misaligned = trap_q;
      cnt_cond        = cc_q;
      cnt_cond_taken  = ct_q;
      cnt_jump        = cj_q;
   end

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Randomized bench for branch_redirect_ctrl against a cycle-level
// behavioural model, plus directed literal checks.
module tb_branch_redirect_ctrl;

   localparam int FC    = 2;
   localparam int CW    = 4;
   localparam int CMAX  = (1 << CW) - 1;

   logic          clk;
   logic          rst_n;
   logic          ex_valid;
   logic [4:0]    ex_BrOp;
   logic          ex_NextPCSrc;
   logic [31:0]   ex_target;
   logic          fetch_ready;
   logic          redirect_valid;
   logic [31:0]   redirect_pc;
   logic          flush;
   logic          busy;
   logic          trap_misaligned;
   logic [CW-1:0] cnt_cond;
   logic [CW-1:0] cnt_cond_taken;
   logic [CW-1:0] cnt_jump;

   branch_redirect_ctrl #(
      .FLUSH_CYCLES(FC),
      .CNT_W(CW)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .ex_valid(ex_valid),
      .ex_BrOp(ex_BrOp),
      .ex_NextPCSrc(ex_NextPCSrc),
      .ex_target(ex_target),
      .fetch_ready(fetch_ready),
      .redirect_valid(redirect_valid),
      .redirect_pc(redirect_pc),
      .flush(flush),
      .busy(busy),
      .trap_misaligned(trap_misaligned),
      .cnt_cond(cnt_cond),
      .cnt_cond_taken(cnt_cond_taken),
      .cnt_jump(cnt_jump)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Model: a pending redirect, a count of flush cycles left after the
   // handshake, the last latched PC, a trap pulse and integer counters.
   bit        started = 0;
   bit        m_pend;
   int        m_tail;
   bit [31:0] m_pc;
   bit        m_trap;
   int        m_cc, m_ct, m_cj;

   always @(posedge clk) begin
      if (!rst_n) begin
         started = 1;
         m_pend  = 0;
         m_tail  = 0;
         m_pc    = 0;
         m_trap  = 0;
         m_cc    = 0;
         m_ct    = 0;
         m_cj    = 0;
      end else begin
         m_trap = 0;
         if (m_pend) begin
            if (fetch_ready) begin
               m_pend = 0;
               m_tail = FC;
            end
         end else if (m_tail > 0) begin
            m_tail--;
         end else if (ex_valid) begin
            bit jmp, cnd, tk;
            jmp = ex_BrOp[4];
            cnd = (ex_BrOp[4:3] == 2'b01);
            tk  = jmp || (cnd && ex_NextPCSrc);
            if (jmp && m_cj < CMAX) m_cj++;
            if (cnd && m_cc < CMAX) m_cc++;
            if (cnd && ex_NextPCSrc && m_ct < CMAX) m_ct++;
            if (tk) begin
               if (ex_target[1:0] == 2'b00) begin
                  m_pend = 1;
                  m_pc   = ex_target;
               end else begin
                  m_trap = 1;
               end
            end
         end
      end
   end

   always @(negedge clk) begin
      if (started) begin
         chk("redirect_valid", 32'(redirect_valid), 32'(m_pend));
         chk("flush", 32'(flush), 32'(m_pend || m_tail > 0));
         chk("busy", 32'(busy), 32'(m_pend || m_tail > 0));
         chk("trap", 32'(trap_misaligned), 32'(m_trap));
         chk("redirect_pc", redirect_pc, m_pc);
         chk("cnt_cond", 32'(cnt_cond), 32'(m_cc));
         chk("cnt_cond_taken", 32'(cnt_cond_taken), 32'(m_ct));
         chk("cnt_jump", 32'(cnt_jump), 32'(m_cj));
      end
   end

   task automatic drive(input logic v, input logic [4:0] op,
                        input logic tk, input logic [31:0] tg);
      ex_valid     = v;
      ex_BrOp      = op;
      ex_NextPCSrc = tk;
      ex_target    = tg;
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 50 && busy; i++) @(negedge clk);
      chk("idle_timeout", 32'(busy), 32'd0);
   endtask

   initial begin
      int nfl;
      int nhs;
      int ncyc;
      rst_n       = 1'b0;
      fetch_ready = 1'b0;
      drive(1'b0, 5'b0, 1'b0, 32'h0);
      repeat (3) @(negedge clk);
      chk("rst_rv", 32'(redirect_valid), 32'd0);
      chk("rst_cnt", 32'(cnt_cond), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // BEQ taken, fetch ready immediately
      fetch_ready = 1'b1;
      drive(1'b1, 5'b01000, 1'b1, 32'h40);
      @(negedge clk);
      drive(1'b0, 5'b0, 1'b0, 32'h0);
      chk("beq_rv", 32'(redirect_valid), 32'd1);
      chk("beq_pc", redirect_pc, 32'h40);
      nfl = 0;
      while (flush && nfl < 20) begin
         nfl++;
         @(negedge clk);
      end
      chk("beq_flush_len", 32'(nfl), 32'd3);
      chk("beq_cc", 32'(cnt_cond), 32'd1);
      chk("beq_ct", 32'(cnt_cond_taken), 32'd1);

      // JAL with backpressure; EX pulses during the wait are ignored
      fetch_ready = 1'b0;
      drive(1'b1, 5'b10000, 1'b0, 32'h100);
      @(negedge clk);
      for (int i = 0; i < 5; i++) begin
         chk("jal_rv", 32'(redirect_valid), 32'd1);
         chk("jal_pc", redirect_pc, 32'h100);
         chk("jal_flush", 32'(flush), 32'd1);
         drive(i[0], 5'b01000, 1'b1, 32'h80);
         @(negedge clk);
      end
      drive(1'b0, 5'b0, 1'b0, 32'h0);
      fetch_ready = 1'b1;
      wait_idle();
      chk("jal_cj", 32'(cnt_jump), 32'd1);
      chk("jal_cc", 32'(cnt_cond), 32'd1);

      // BNE not taken, then non-branch with NextPCSrc set
      drive(1'b1, 5'b01001, 1'b0, 32'h200);
      @(negedge clk);
      drive(1'b1, 5'b00000, 1'b1, 32'h300);
      chk("bne_rv", 32'(redirect_valid), 32'd0);
      chk("bne_cc", 32'(cnt_cond), 32'd2);
      chk("bne_ct", 32'(cnt_cond_taken), 32'd1);
      @(negedge clk);
      drive(1'b0, 5'b0, 1'b0, 32'h0);
      chk("nb_rv", 32'(redirect_valid), 32'd0);
      chk("nb_cc", 32'(cnt_cond), 32'd2);
      chk("nb_cj", 32'(cnt_jump), 32'd1);

      // Misaligned jump target
      drive(1'b1, 5'b11000, 1'b0, 32'h42);
      @(negedge clk);
      drive(1'b0, 5'b0, 1'b0, 32'h0);
      chk("mis_trap", 32'(trap_misaligned), 32'd1);
      chk("mis_rv", 32'(redirect_valid), 32'd0);
      chk("mis_busy", 32'(busy), 32'd0);
      chk("mis_cj", 32'(cnt_jump), 32'd2);
      @(negedge clk);
      chk("mis_trap_end", 32'(trap_misaligned), 32'd0);

      // 20 back-to-back taken BLTs: one every 4 cycles, counters saturate
      drive(1'b1, 5'b01100, 1'b1, 32'h400);
      nhs  = 0;
      ncyc = 0;
      while (nhs < 20 && ncyc < 200) begin
         @(negedge clk);
         ncyc++;
         if (redirect_valid) nhs++;
      end
      drive(1'b0, 5'b0, 1'b0, 32'h0);
      chk("b2b_count", 32'(nhs), 32'd20);
      chk("b2b_cycles", 32'(ncyc), 32'd77);
      wait_idle();
      chk("sat_cc", 32'(cnt_cond), 32'hF);
      chk("sat_ct", 32'(cnt_cond_taken), 32'hF);

      // Reset while REDIRECT is waiting
      fetch_ready = 1'b0;
      drive(1'b1, 5'b10000, 1'b0, 32'h500);
      @(negedge clk);
      drive(1'b0, 5'b0, 1'b0, 32'h0);
      chk("pre_rst_rv", 32'(redirect_valid), 32'd1);
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      chk("mid_rst_rv", 32'(redirect_valid), 32'd0);
      chk("mid_rst_flush", 32'(flush), 32'd0);
      chk("mid_rst_pc", redirect_pc, 32'h0);
      chk("mid_rst_cj", 32'(cnt_jump), 32'd0);
      @(negedge clk);
      chk("post_rst_busy", 32'(busy), 32'd0);

      // Randomized traffic
      for (int i = 0; i < 3000; i++) begin
         logic [31:0] tg;
         tg = $urandom;
         if ($urandom_range(3) != 0) tg[1:0] = 2'b00;
         drive(1'($urandom_range(1)), 5'($urandom_range(31)),
               1'($urandom_range(1)), tg);
         fetch_ready = ($urandom_range(9) < 6);
         rst_n       = ($urandom_range(199) != 0);
         @(negedge clk);
      end
      rst_n = 1'b1;
      drive(1'b0, 5'b0, 1'b0, 32'h0);
      @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
